mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified instruction/data memory between the multicycle core's control path (fetch, load and store states) and a debug/loader requester.
Each side gets a registered req/ack handshake. The block sequences every access through issue, wait-state and response phases with a configurable memory read latency.
It sits between the core datapath's memory interface and the memory macro.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
MEM_LAT, 1, cycles from the issue cycle to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  core access request; level, held until ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  core word address
cpu_wdata  in  DATA_W  core write data
cpu_ack  out  1  one-cycle completion pulse to the core
dbg_req  in  1  debug/loader request; same rules as cpu_req
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse to debug
rdata  out  DATA_W  registered read data, shared by both requesters
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE
owner  out  1  0 = core, 1 = debug; requester of the current or last access

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, ACK.
- Reset (async, immediate):
  - state = IDLE.
  - Outputs: mem_en = mem_we = 0, cpu_ack = dbg_ack = 0, busy = 0.
  - Registers: rdata = 0, mem_addr = 0, mem_wdata = 0, owner = 0, last_owner = 1 (the core wins the first tie).
  - Reset mid-access drops the transaction; no ack is ever produced for it. A write asserted in ISSUE is cut off as mem_we falls.
- IDLE:
  - With no request pending, stay in IDLE.
  - Otherwise select a requester and latch its we, addr and wdata into internal registers (mem_addr and mem_wdata update at this edge). Set owner, go to ISSUE.
- Arbitration: round-robin. If only one req is high, grant it. If both are high, grant the requester that is not last_owner. last_owner updates at grant.
- ISSUE (exactly 1 cycle):
  - mem_en = 1, mem_we = latched we.
  - Write: go to ACK.
  - Read: go to WAIT with the counter loaded to MEM_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 0, capture mem_rdata into rdata at this edge and go to ACK.
  - WAIT therefore lasts MEM_LAT cycles.
- ACK (1 cycle):
  - Assert the owner's ack only; the other ack stays 0. Go to IDLE.
- Latency from the first IDLE cycle with req high (cycle 0):
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+MEM_LAT, with rdata valid in that cycle.
- Handshake:
  - The requester advances on the edge ending its ack cycle and drops req in the next cycle.
  - A req still high in the IDLE cycle after ack is a new request.
  - Requests arriving while busy are held off (no ack) until IDLE.
- rdata holds its value until the next read capture; writes do not modify it.
- The non-granted requester's inputs are ignored from grant until return to IDLE, so input changes never corrupt the latched access.
- mem_en and mem_we are decoded from state only; they are 0 in IDLE, WAIT and ACK.

Optional Feature:
MEM_ARB_CPU_PRIO_EN:
- Defined: fixed priority; when both requests are high, cpu_req always wins. last_owner is unused.
- Undefined: round-robin as above.
- Handshake timing and latency are identical in both builds.

Test Plan:
- Reset, then single core read of addr 0x10, with mem returning 0xDEADBEEF and MEM_LAT=1 -> mem_en=1, mem_we=0 in cycle 1; cpu_ack=1 and rdata=0xDEADBEEF in cycle 3; dbg_ack stays 0.
- Debug write of addr 0x20, data 0x12345678 -> mem_en=1, mem_we=1, mem_wdata=0x12345678 in cycle 1; dbg_ack in cycle 2; rdata unchanged.
- Both requesting reads continuously from reset -> grants alternate core, debug, core; owner toggles 0,1,0. With MEM_ARB_CPU_PRIO_EN defined, the core is granted every time.
- MEM_LAT=3 core read -> busy high for cycles 1..5; capture happens at the end of cycle 4; cpu_ack in cycle 5.
- Core req raised while a debug access is in WAIT -> no cpu_ack until the debug ack; the core is granted in the following IDLE cycle.
- Assert reset during WAIT -> mem_en, acks and busy drop immediately; no ack after release; the next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between the core and a debug/loader requester.
// Optional macro MEM_ARB_CPU_PRIO_EN selects fixed core priority instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state;
    logic       we_q;
    logic [3:0] cnt;
    logic       grant_dbg;

`ifdef MEM_ARB_CPU_PRIO_EN
    always_comb grant_dbg = dbg_req & ~cpu_req;
`else
    logic last_owner;

    // On a tie the side that did not win last time gets the port.
    always_comb grant_dbg = dbg_req & (~cpu_req | ~last_owner);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            cnt       <= 4'd0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
`ifndef MEM_ARB_CPU_PRIO_EN
            last_owner <= 1'b1;
`endif
        end else begin
            // Strobes and acks are single-cycle; the case below re-asserts them on entry.
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req | dbg_req) begin
                        owner     <= grant_dbg;
`ifndef MEM_ARB_CPU_PRIO_EN
                        last_owner <= grant_dbg;
`endif
                        we_q      <= grant_dbg ? dbg_we    : cpu_we;
                        mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_dbg ? dbg_we    : cpu_we;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        cpu_ack <= ~owner;
                        dbg_ack <= owner;
                        state   <= ACK;
                    end else begin
                        cnt   <= LAT_M1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rdata   <= mem_rdata;
                        cpu_ack <= ~owner;
                        dbg_ack <= owner;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a schedule-based reference model and memory model.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: each access is a schedule (grant cycle g, ack cycle e) rather than a state machine.
    logic [31:0] mem [256];
    bit          filled = 0;
    bit          m_act, m_we, m_own, m_last;
    int          m_g, m_end, rd_due;
    logic [31:0] m_addr, m_wd, m_rd, m_rdv, mem_q;

    always @(negedge clk) begin
        bit ex_en, ex_ack, ex_busy, pick;
        if (!filled) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            filled = 1;
        end
        if (reset) begin
            m_act = 0; m_own = 0; m_last = 1; m_addr = 0; m_wd = 0; m_rd = 0; rd_due = -1;
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_en", {31'b0, mem_en}, 0);
            chk("rst_acks", {30'b0, cpu_ack, dbg_ack}, 0);
            chk("rst_owner", {31'b0, owner}, 0);
            chk("rst_rdata", rdata, 0);
        end else begin
            if (m_act && !m_we && cyc == m_end) m_rd = m_rdv;
            ex_busy = m_act && cyc > m_g && cyc <= m_end;
            ex_en   = m_act && cyc == m_g + 1;
            ex_ack  = m_act && cyc == m_end;
            chk("m_busy", {31'b0, busy}, {31'b0, ex_busy});
            chk("m_en", {31'b0, mem_en}, {31'b0, ex_en});
            chk("m_we", {31'b0, mem_we}, {31'b0, ex_en && m_we});
            chk("m_cpu_ack", {31'b0, cpu_ack}, {31'b0, ex_ack && !m_own});
            chk("m_dbg_ack", {31'b0, dbg_ack}, {31'b0, ex_ack && m_own});
            chk("m_owner", {31'b0, owner}, {31'b0, m_own});
            chk("m_addr", mem_addr, m_addr);
            chk("m_wdata", mem_wdata, m_wd);
            chk("m_rdata", rdata, m_rd);
            if (ex_en) begin
                if (m_we) mem[m_addr[7:0]] = m_wd;
                else begin
                    rd_due = cyc + LAT;
                    mem_q  = mem[m_addr[7:0]];
                end
            end
            if ((!m_act || cyc > m_end) && (cpu_req || dbg_req)) begin
                if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_CPU_PRIO_EN
                    pick = 0;
`else
                    pick = !m_last;
`endif
                end else pick = dbg_req;
                m_act  = 1;
                m_g    = cyc;
                m_own  = pick;
                m_last = pick;
                m_we   = pick ? dbg_we : cpu_we;
                m_addr = pick ? dbg_addr : cpu_addr;
                m_wd   = pick ? dbg_wdata : cpu_wdata;
                m_end  = cyc + (m_we ? 2 : 2 + LAT);
                if (!m_we) m_rdv = mem[m_addr[7:0]];
            end
        end
        // Memory data is only valid in the one cycle it is due; otherwise noise.
        mem_rdata = (!reset && cyc == rd_due) ? mem_q : $urandom;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v_busy, v_en, v_we, v_cack, v_dack, v_own, v_wd1, v_rd;

    // Records per-cycle outputs from cycle 0 (the cycle the request is presented).
    task automatic window(input int ncyc, input int cpu_at, input bit hold);
        bit c, d;
        v_busy = 0; v_en = 0; v_we = 0; v_cack = 0; v_dack = 0; v_own = 0; v_wd1 = 0; v_rd = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            v_busy[i] = busy; v_en[i] = mem_en; v_we[i] = mem_we;
            v_cack[i] = cpu_ack; v_dack[i] = dbg_ack; v_own[i] = owner;
            if (i == 1) v_wd1 = mem_wdata;
            c = cpu_ack; d = dbg_ack;
            if (c || d) v_rd = rdata;
            tick;
            if (!hold && c) cpu_req = 0;
            if (!hold && d) dbg_req = 0;
            if (i + 1 == cpu_at) cpu_req = 1;
        end
    endtask

    initial begin
        reset = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (2) tick;
        reset = 0;
        tick;

        // Core write of DEADBEEF to 0x10: ack in cycle 2.
        cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_req = 1;
        window(6, -1, 0);
        chk("w0_busy", v_busy, 32'h6);
        chk("w0_en", v_en, 32'h2);
        chk("w0_we", v_we, 32'h2);
        chk("w0_cack", v_cack, 32'h4);
        chk("w0_wdata", v_wd1, 32'hDEADBEEF);

        // Core read of 0x10, MEM_LAT=3: busy cycles 1..5, ack in cycle 5.
        cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1;
        window(8, -1, 0);
        chk("r1_busy", v_busy, 32'h3E);
        chk("r1_en", v_en, 32'h2);
        chk("r1_we", v_we, 32'h0);
        chk("r1_cack", v_cack, 32'h20);
        chk("r1_dack", v_dack, 32'h0);
        chk("r1_rdata", v_rd, 32'hDEADBEEF);

        // Debug write leaves rdata alone.
        dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; dbg_req = 1;
        window(6, -1, 0);
        chk("w2_dack", v_dack, 32'h4);
        chk("w2_cack", v_cack, 32'h0);
        chk("w2_we", v_we, 32'h2);
        chk("w2_wdata", v_wd1, 32'h12345678);
        chk("w2_rdata", v_rd, 32'hDEADBEEF);

        // Both requesting reads continuously.
        cpu_we = 0; cpu_addr = 32'h20; dbg_we = 0; dbg_addr = 32'h10; cpu_req = 1; dbg_req = 1;
        window(18, -1, 1);
        cpu_req = 0; dbg_req = 0;
`ifdef MEM_ARB_CPU_PRIO_EN
        chk("rr_cack", v_cack, 32'h20820);
        chk("rr_dack", v_dack, 32'h0);
`else
        chk("rr_cack", v_cack, 32'h20020);
        chk("rr_dack", v_dack, 32'h800);
        chk("rr_own", {29'b0, v_own[17], v_own[11], v_own[5]}, 32'h2);
`endif

        // Core request arrives while the debug read is waiting.
        dbg_we = 0; dbg_addr = 32'h20; dbg_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        window(14, 3, 0);
        chk("hold_dack", v_dack, 32'h20);
        chk("hold_cack", v_cack, 32'h800);
        chk("hold_en", v_en, 32'h82);
        chk("hold_busy", v_busy, 32'hFBE);
        chk("hold_own7", {31'b0, v_own[7]}, 32'h0);

        // Reset in WAIT drops the access.
        cpu_we = 0; cpu_addr = 32'h44; cpu_req = 1;
        @(negedge clk); tick; @(negedge clk); tick; @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_en", {31'b0, mem_en}, 32'h0);
        chk("arst_acks", {30'b0, cpu_ack, dbg_ack}, 32'h0);
        tick; cpu_req = 0;
        tick; reset = 0;
        window(10, -1, 0);
        chk("arst_no_ack", v_cack | v_dack, 32'h0);
        chk("arst_idle", v_busy, 32'h0);
        cpu_we = 1; cpu_addr = 32'h55; cpu_wdata = 32'hA5A5_0001; cpu_req = 1;
        window(6, -1, 0);
        chk("arst_after", v_cack, 32'h4);

        // Random traffic, checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            bit c, d;
            @(negedge clk);
            c = cpu_ack; d = dbg_ack;
            tick;
            reset = (n % 700 == 350);
            if (cpu_req) begin
                if (c && $urandom_range(0, 3) != 0) cpu_req = 0;
            end else begin
                cpu_we = $urandom_range(0, 1); cpu_wdata = $urandom; cpu_addr = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    cpu_addr = $urandom_range(0, 255);
                    cpu_req  = 1;
                end
            end
            if (dbg_req) begin
                if (d && $urandom_range(0, 3) != 0) dbg_req = 0;
            end else begin
                dbg_we = $urandom_range(0, 1); dbg_wdata = $urandom; dbg_addr = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    dbg_addr = $urandom_range(0, 255);
                    dbg_req  = 1;
                end
            end
        end
        reset = 0; cpu_req = 0; dbg_req = 0;
        repeat (12) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
